// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and helpers for the VGA timing and pixel paths.
package vga_timing_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned FRAME_CNT_W = 8;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    // Inclusive range test of a raster coordinate.
    function automatic logic in_range(input logic [COORD_W-1:0] pos,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (32'(pos) >= lo) && (32'(pos) <= hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with per-stage async reset value; DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int unsigned       WIDTH     = 1,
    parameter int unsigned       DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, reset, en};
            assign dout      = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i];
                end
                if (en) begin
                    stage_d[0] = din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, strobes and sync decode; syncs/active re-aligned to the pixel pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    output logic [COORD_W-1:0]     hpos,
    output logic [COORD_W-1:0]     vpos,
    output logic                   active,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   vga_h_sync,
    output logic                   vga_v_sync,
    output logic                   active_d
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    localparam logic       SYNC_OFF  = ~SYNC_POL;
    localparam logic [2:0] DLY_RESET = {SYNC_OFF, SYNC_OFF, 1'b0};

    logic [COORD_W-1:0]     hpos_q, hpos_d;
    logic [COORD_W-1:0]     vpos_q, vpos_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   act_q, act_d;
    logic                   lstart_q, lstart_d;
    logic                   fstart_q, fstart_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic [2:0]             dly_out;

    // Counters advance on enable; all decodes come from the next counts so the
    // registered flags describe the coordinates shown alongside them.
    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        fcnt_d = fcnt_q;
        if (en) begin
            if (hpos_q == COORD_W'(H_TOTAL - 1)) begin
                hpos_d = '0;
                if (vpos_q == COORD_W'(V_TOTAL - 1)) begin
                    vpos_d = '0;
                    fcnt_d = fcnt_q + FRAME_CNT_W'(1);
                end else begin
                    vpos_d = vpos_q + COORD_W'(1);
                end
            end else begin
                hpos_d = hpos_q + COORD_W'(1);
            end
        end
        act_d    = (hpos_d < COORD_W'(H_ACTIVE)) && (vpos_d < COORD_W'(V_ACTIVE));
        lstart_d = (hpos_d == '0);
        fstart_d = lstart_d && (vpos_d == '0);
        hsync_d  = in_range(hpos_d, HS_START, HS_END) ? SYNC_POL : SYNC_OFF;
        vsync_d  = in_range(vpos_d, VS_START, VS_END) ? SYNC_POL : SYNC_OFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q   <= '0;
            vpos_q   <= '0;
            fcnt_q   <= '0;
            act_q    <= 1'b1;
            lstart_q <= 1'b1;
            fstart_q <= 1'b1;
            hsync_q  <= SYNC_OFF;
            vsync_q  <= SYNC_OFF;
        end else begin
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            fcnt_q   <= fcnt_d;
            act_q    <= act_d;
            lstart_q <= lstart_d;
            fstart_q <= fstart_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (DLY_RESET)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .din   ({vsync_q, hsync_q, act_q}),
        .dout  (dly_out)
    );

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_count = fcnt_q;
    assign active      = act_q;
    assign line_start  = lstart_q;
    assign frame_start = fstart_q;
    assign {vga_v_sync, vga_h_sync, active_d} = dly_out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-enable bench for vga_timing_gen on a shrunken raster, against an enabled-cycle-count model.
module tb_vga_timing_gen;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int PD = 2;

    logic clk = 1'b0;
    logic reset;
    logic en;
    always #5 clk = ~clk;

    logic [9:0] hpos, vpos, z_hpos, z_vpos;
    logic [7:0] frame_count, z_frame_count;
    logic active, line_start, frame_start, vga_h_sync, vga_v_sync, active_d;
    logic z_active, z_line_start, z_frame_start, z_vga_h_sync, z_vga_v_sync, z_active_d;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .PIPE_DELAY(PD)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .hpos(hpos), .vpos(vpos), .active(active), .line_start(line_start),
        .frame_start(frame_start), .frame_count(frame_count),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .active_d(active_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .PIPE_DELAY(0)
    ) dut0 (
        .clk(clk), .reset(reset), .en(en),
        .hpos(z_hpos), .vpos(z_vpos), .active(z_active), .line_start(z_line_start),
        .frame_start(z_frame_start), .frame_count(z_frame_count),
        .vga_h_sync(z_vga_h_sync), .vga_v_sync(z_vga_v_sync), .active_d(z_active_d)
    );

    int n;          // enabled cycles since reset released
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, got, exp, n);
    endtask

    function automatic int hs_raw(input int h);
        return (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
    endfunction

    function automatic int vs_raw(input int v);
        return (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
    endfunction

    function automatic int act_raw(input int h, input int v);
        return (h < HA && v < VA) ? 1 : 0;
    endfunction

    // Position after k enabled cycles is plain division of k by line/frame length.
    task automatic check_all();
        int h, v, f, ph, pv;
        int e_hs, e_vs, e_ad;
        h = n % HT;
        v = (n / HT) % VT;
        f = (n / FRAME) % 256;
        if (n >= PD) begin
            ph = (n - PD) % HT;
            pv = ((n - PD) / HT) % VT;
            e_hs = hs_raw(ph);
            e_vs = vs_raw(pv);
            e_ad = act_raw(ph, pv);
        end else begin
            e_hs = 1;
            e_vs = 1;
            e_ad = 0;
        end
        check("hpos", int'(hpos), h);
        check("vpos", int'(vpos), v);
        check("frame_count", int'(frame_count), f);
        check("active", int'(active), act_raw(h, v));
        check("line_start", int'(line_start), (h == 0) ? 1 : 0);
        check("frame_start", int'(frame_start), (h == 0 && v == 0) ? 1 : 0);
        check("h_sync_d2", int'(vga_h_sync), e_hs);
        check("v_sync_d2", int'(vga_v_sync), e_vs);
        check("active_d2", int'(active_d), e_ad);
        check("d0_hpos", int'(z_hpos), h);
        check("d0_h_sync", int'(z_vga_h_sync), hs_raw(h));
        check("d0_v_sync", int'(z_vga_v_sync), vs_raw(v));
        check("d0_active_d", int'(z_active_d), act_raw(h, v));
    endtask

    task automatic step(input bit e);
        en = e;
        @(posedge clk);
        if (!reset && en) n = n + 1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int target;
        int iter;
        reset = 1'b1;
        en    = 1'b0;
        n     = 0;
        @(negedge clk);
        check_all();
        step(1'b1);
        step(1'b1);
        reset = 1'b0;

        // Random enable duty cycle over several frames.
        repeat (3000) step($urandom_range(0, 2) != 0);

        // Asynchronous reset mid-frame, sampled before any clock edge.
        repeat ($urandom_range(40, 200)) step(1'b1);
        #2;
        reset = 1'b1;
        n = 0;
        #1;
        check_all();
        @(negedge clk);
        check_all();
        step(1'b1);
        reset = 1'b0;

        // Run past 256 frames so frame_count wraps.
        target = 257 * FRAME + 10;
        iter = 0;
        while (n < target && iter < 60000) begin
            step($urandom_range(0, 9) != 0);
            iter++;
        end
        check("frame_budget", (n >= target) ? 1 : 0, 1);
        check("frame_wrapped", int'(frame_count), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA path, clocked from the 25.175 MHz PLL output and held by the top-level power-on reset. It sits directly upstream of the pixel/colour generator inside `vga_demo`. It produces the pixel coordinates, active-video flag and frame/line strobes that the pixel generator consumes. It also produces `vga_h_sync`/`vga_v_sync` delayed to line up with that generator's pipelined colour output.

## Interface
- `H_ACTIVE` 640; `H_FP` 16; `H_SYNC` 96; `H_BP` 48: horizontal segment lengths, in pixels.
- `V_ACTIVE` 480; `V_FP` 10; `V_SYNC` 2; `V_BP` 33: vertical segment lengths, in lines.
- `SYNC_POL` 0: sync asserted level (0 = active-low, as 640x480 requires).
- `PIPE_DELAY` 2: pixel-generator latency in enabled cycles. Legal range 0..7.
- `clk` in 1: pixel clock (25.175 MHz).
- `reset` in 1: asynchronous, active-high.
- `en` in 1: pixel enable. Tie to 1 when `clk` is the pixel clock.
- `hpos` out 10: horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800).
- `vpos` out 10: vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525).
- `active` out 1: `hpos` < H_ACTIVE and `vpos` < V_ACTIVE.
- `line_start` out 1: high while `hpos` == 0.
- `frame_start` out 1: high while `hpos` == 0 and `vpos` == 0.
- `frame_count` out 8: frames completed, wraps modulo 256.
- `vga_h_sync` out 1: horizontal sync, delayed by PIPE_DELAY.
- `vga_v_sync` out 1: vertical sync, delayed by PIPE_DELAY.
- `active_d` out 1: `active` delayed by PIPE_DELAY.

## Operation
- **Horizontal counter.** Advances only in cycles with `en`=1. Wraps from H_TOTAL-1 to 0.
- **Vertical counter.** Increments only on that horizontal wrap. Wraps from V_TOTAL-1 to 0.
- **Frame counter.** `frame_count` increments on the vertical wrap, i.e. when (799,524) steps to (0,0). It wraps 255 to 0.
- **Raw sync decode** (undelayed):
  - hsync is asserted for `hpos` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
  - vsync is asserted for `vpos` in [490, 491].
- **Output registers.** All outputs are flops, with no combinational path from input to output.
  - `active`, `line_start` and `frame_start` are decoded from the next-count value and registered. They therefore always describe the `hpos`/`vpos` pair visible in the same cycle.
- **Delay line.** Three bits wide: raw hsync, raw vsync and `active`. It has PIPE_DELAY stages and shifts only when `en`=1. With PIPE_DELAY=0 the delayed outputs equal the raw values.
- **`en` low.** Every register, the delay line included, holds its value.
- **Reset values** (asynchronous):
  - `hpos`=0, `vpos`=0, `frame_count`=0.
  - `active`=1, `line_start`=1, `frame_start`=1, because (0,0) is an active pixel.
  - All delay stages are loaded with deasserted syncs (1 for SYNC_POL=0) and `active`=0. The delayed outputs therefore show blanking with no sync during the first PIPE_DELAY enabled cycles.
- **Reset mid-frame.** Takes effect immediately, with no partial-line completion. Sequencing restarts at (0,0) on the first enabled cycle after `reset` falls.

## Timing
- Per enabled cycle, (h,v) steps to (h+1,v); (799,v) steps to (0,v+1); (799,524) steps to (0,0).
- Line = 800 enabled cycles; frame = 420 000 enabled cycles.
- Delayed-output latency:
  - `vga_h_sync`, `vga_v_sync` and `active_d` lag the raw values for the displayed `hpos`/`vpos` by exactly PIPE_DELAY enabled cycles.
  - Example: with PIPE_DELAY=2, `vga_h_sync` first goes low two enabled cycles after `hpos` reads 656.
- Simultaneous horizontal and vertical wrap updates `hpos`, `vpos` and `frame_count` in the same edge.
- `frame_start` is a one-enabled-cycle strobe per frame. It stays high for as many clocks as `en` is held low while at (0,0).

## Structure
- Shared package `vga_timing_pkg` holds:
  - the 640x480 segment constants and the derived H_TOTAL/V_TOTAL;
  - the sync start/end positions;
  - the coordinate width (10).
- The pixel generator imports the same package.
- One sub-module: `vga_delay_line` (WIDTH, DEPTH, RESET_VAL; per-stage enable, async reset). It is instantiated once, 3 bits wide.
- Counters and decode stay in the top module. Expected size is about 150–200 lines in total.

## Test plan
- Release reset with `en`=1 and PIPE_DELAY=2 → `hpos` counts 0..799, and `vpos` increments exactly when `hpos` wraps 799→0; `vga_h_sync` is low for 96 cycles, first low at counter 656+2.
- Run one full frame → 420 000 cycles between `frame_start` pulses; `vga_v_sync` low for 1600 cycles; `active_d` high for 307 200 cycles; `frame_count` 0→1.
- Toggle `en` at 50 % → line period becomes 1600 clocks; outputs are frozen on every `en`=0 clock; delayed sync widths double in clocks.
- Assert `reset` at (400,300) → within the same cycle `hpos`=0, `vpos`=0, `frame_count`=0, `vga_h_sync`=`vga_v_sync`=1, `active_d`=0; after release, first `active_d`=1 appears after 2 enabled cycles.
- Preload 255 frames and let the next frame complete → `frame_count` wraps to 0 on the (799,524)→(0,0) edge, coinciding with `frame_start`.
- PIPE_DELAY=0 → delayed outputs match the raw decode of the current `hpos`/`vpos` in every cycle.
